// File: rtl/eth_phy_loopback.sv
// eth_phy_loopback: folds the block-oriented TX PHY stream back into
// the beat-oriented MAC stream, with gearbox stalls and cancel injection.
module eth_phy_loopback #(
  parameter int DATA_W         = 16,
  parameter int BLOCK_N        = 8,
  parameter int START_W        = 1,
  parameter int GEARBOX_PERIOD = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         phy_ready_o,
  input  logic                         tx_ctrl_v_i,
  input  logic [DATA_W-1:0]            tx_data_i,
  input  logic [START_W-1:0]           tx_start_i,
  input  logic                         tx_idle_i,
  input  logic                         tx_term_i,
  input  logic [$clog2(BLOCK_N+1)-1:0] tx_term_len_i,
  input  logic                         cancel_i,
  output logic                         mac_valid_o,
  output logic [DATA_W-1:0]            mac_data_o,
  output logic [START_W-1:0]           mac_start_o,
  output logic                         mac_term_o,
  output logic [$clog2(DATA_W/8+1)-1:0] mac_len_o,
  output logic                         phy_cancel_o,
  output logic                         err_o
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int BPB    = BLOCK_N / KEEP_W;
  localparam int RW     = $clog2(BLOCK_N + 1);
  localparam int LW     = $clog2(KEEP_W + 1);
  localparam int BW     = (BPB > 1) ? $clog2(BPB) : 1;
  localparam int GW     = (GEARBOX_PERIOD > 1) ?
                          $clog2(GEARBOX_PERIOD) : 1;

  localparam logic [BW-1:0] BC_LAST  = BW'(BPB - 1);
  localparam logic [BW-1:0] BC_ONE   = BW'((BPB > 1) ? 1 : 0);
  localparam logic [LW-1:0] LEN_FULL = LW'(KEEP_W);
  localparam logic [RW-1:0] REM_FULL = RW'(KEEP_W);

  typedef enum logic [2:0] {
    IDLE, DATA, TERM, PAD, DROP
  } state_t;

  state_t          state, nxt;
  logic [BW-1:0]   bc, bc_n, bc_inc;
  logic [RW-1:0]   rem, rem_n, r;
  logic            rdy;
  logic            acc, st;
  logic            do_start, do_term;
  logic            v_n, t_n, c_n, e_n;
  logic [START_W-1:0] s_n;
  logic [LW-1:0]   l_n;

  // Control-block flag carries no extra information for the loopback.
  logic unused_ctrl;
  assign unused_ctrl = tx_ctrl_v_i;

  assign phy_ready_o = rdy;
  assign acc    = rdy & ~tx_idle_i;
  assign st     = |tx_start_i;
  assign bc_inc = (bc == BC_LAST) ? '0 : bc + BW'(1);

  if (GEARBOX_PERIOD > 0) begin : g_gearbox
    localparam logic [GW-1:0] G_LAST = GW'(GEARBOX_PERIOD - 1);
    logic [GW-1:0] g, g_nxt;
    assign g_nxt = (g == G_LAST) ? '0 : g + GW'(1);
    // Free-running gearbox slot counter; ready drops on the last slot.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        g   <= '0;
        rdy <= 1'b0;
      end else begin
        g   <= g_nxt;
        rdy <= (g_nxt != G_LAST);
      end
    end
  end else begin : g_nogearbox
    // No stalls: ready comes up after reset release and stays up.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) rdy <= 1'b0;
      else       rdy <= 1'b1;
    end
  end

  // Next-state, beat accounting and next output values.
  always_comb begin
    nxt      = state;
    bc_n     = bc;
    rem_n    = rem;
    v_n      = 1'b0;
    s_n      = '0;
    t_n      = 1'b0;
    l_n      = '0;
    c_n      = 1'b0;
    e_n      = err_o;
    do_start = 1'b0;
    do_term  = 1'b0;
    r        = (state == TERM) ? rem : tx_term_len_i;

    if (!rdy && !tx_idle_i) e_n = 1'b1;

    unique case (state)
      IDLE: begin
        if (acc) begin
          if (st) do_start = 1'b1;
          else    e_n      = 1'b1;
        end
      end
      DATA, TERM: begin
        if (cancel_i) begin
          c_n = 1'b1;
          nxt = DROP;
        end else if (acc) begin
          if (st) begin
            e_n      = 1'b1;
            c_n      = 1'b1;
            do_start = 1'b1;
          end else if (state == TERM || tx_term_i) begin
            do_term = 1'b1;
            if (state == DATA && bc != '0) e_n = 1'b1;
          end else begin
            v_n  = 1'b1;
            l_n  = LEN_FULL;
            bc_n = bc_inc;
          end
        end
      end
      PAD: begin
        if (acc) begin
          if (st) begin
            e_n      = 1'b1;
            do_start = 1'b1;
          end else begin
            bc_n = bc_inc;
            if (bc == BC_LAST) nxt = IDLE;
          end
        end
      end
      DROP: begin
        if (tx_idle_i) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase

    if (do_start) begin
      v_n   = 1'b1;
      s_n   = tx_start_i;
      l_n   = LEN_FULL;
      bc_n  = BC_ONE;
      rem_n = '0;
      nxt   = DATA;
    end

    if (do_term) begin
      v_n  = 1'b1;
      bc_n = bc_inc;
      if (r > REM_FULL) begin
        l_n   = LEN_FULL;
        rem_n = r - REM_FULL;
        nxt   = TERM;
      end else begin
        l_n   = LW'(r);
        t_n   = 1'b1;
        rem_n = '0;
        nxt   = (bc == BC_LAST) ? IDLE : PAD;
      end
    end
  end

  // State, counters and the registered MAC-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bc           <= '0;
      rem          <= '0;
      mac_valid_o  <= 1'b0;
      mac_data_o   <= '0;
      mac_start_o  <= '0;
      mac_term_o   <= 1'b0;
      mac_len_o    <= '0;
      phy_cancel_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state        <= nxt;
      bc           <= bc_n;
      rem          <= rem_n;
      mac_valid_o  <= v_n;
      mac_data_o   <= v_n ? tx_data_i : '0;
      mac_start_o  <= s_n;
      mac_term_o   <= t_n;
      mac_len_o    <= l_n;
      phy_cancel_o <= c_n;
      err_o        <= e_n;
    end
  end

endmodule

// File: tb/tb_eth_phy_loopback.sv
// tb_eth_phy_loopback: directed frames with a queued scoreboard on the
// MAC side, plus a second instance exercising gearbox stalls.
module tb_eth_phy_loopback;

  typedef struct packed {
    logic        v;
    logic        c;
    logic        s;
    logic        t;
    logic [1:0]  l;
    logic [15:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;

  logic        ctrl_v, idle, start, term, cancel;
  logic [15:0] data;
  logic [3:0]  term_len;
  logic        m_ready, m_valid, m_start, m_term, m_cancel, m_err;
  logic [15:0] m_data;
  logic [1:0]  m_len;

  logic        g_idle, g_start;
  logic        gb_ready, gb_valid, gb_start, gb_term, gb_cancel, gb_err;
  logic [15:0] gb_data;
  logic [1:0]  gb_len;

  beat_t       q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        done = 1'b0;

  always #5 clk = ~clk;

  eth_phy_loopback #(
    .DATA_W(16), .BLOCK_N(8), .START_W(1), .GEARBOX_PERIOD(0)
  ) dut (
    .clk(clk), .reset(reset), .phy_ready_o(m_ready),
    .tx_ctrl_v_i(ctrl_v), .tx_data_i(data), .tx_start_i(start),
    .tx_idle_i(idle), .tx_term_i(term), .tx_term_len_i(term_len),
    .cancel_i(cancel), .mac_valid_o(m_valid), .mac_data_o(m_data),
    .mac_start_o(m_start), .mac_term_o(m_term), .mac_len_o(m_len),
    .phy_cancel_o(m_cancel), .err_o(m_err)
  );

  eth_phy_loopback #(
    .DATA_W(16), .BLOCK_N(8), .START_W(1), .GEARBOX_PERIOD(4)
  ) gb (
    .clk(clk), .reset(reset), .phy_ready_o(gb_ready),
    .tx_ctrl_v_i(g_start), .tx_data_i(16'h5A5A), .tx_start_i(g_start),
    .tx_idle_i(g_idle), .tx_term_i(1'b0), .tx_term_len_i(4'd0),
    .cancel_i(1'b0), .mac_valid_o(gb_valid), .mac_data_o(gb_data),
    .mac_start_o(gb_start), .mac_term_o(gb_term), .mac_len_o(gb_len),
    .phy_cancel_o(gb_cancel), .err_o(gb_err)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  task automatic issue(input logic [15:0] d, input logic s,
                       input logic t, input logic [3:0] tl,
                       input logic c);
    @(negedge clk);
    data = d; start = s; term = t; term_len = tl;
    cancel = c; idle = 1'b0; ctrl_v = s | t;
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      idle = 1'b1; start = 1'b0; term = 1'b0;
      cancel = 1'b0; ctrl_v = 1'b0;
    end
  endtask

  task automatic exp_beat(input logic [15:0] d, input logic s,
                          input logic t, input logic [1:0] l);
    q.push_back('{v: 1'b1, c: 1'b0, s: s, t: t, l: l, d: d});
  endtask

  task automatic exp_cancel();
    q.push_back('{v: 1'b0, c: 1'b1, s: 1'b0, t: 1'b0,
                  l: 2'd0, d: 16'h0});
  endtask

  task automatic exp_restart(input logic [15:0] d);
    q.push_back('{v: 1'b1, c: 1'b1, s: 1'b1, t: 1'b0,
                  l: 2'd2, d: d});
  endtask

  task automatic data_beats(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      issue(base + 16'(i), 1'b0, 1'b0, 4'd0, 1'b0);
      exp_beat(base + 16'(i), 1'b0, 1'b0, 2'd2);
    end
  endtask

  task automatic pad_beats(input int n);
    for (int i = 0; i < n; i++)
      issue(16'hDEAD, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    ctrl_v = 1'b0; idle = 1'b1; start = 1'b0; term = 1'b0;
    cancel = 1'b0; data = '0; term_len = '0;
    g_idle = 1'b1; g_start = 1'b0;

    fork
      begin : monitor
        beat_t act, e;
        while (!done) begin
          @(negedge clk);
          if (!reset && (m_valid || m_cancel)) begin
            act = '{v: m_valid, c: m_cancel, s: m_start,
                    t: m_term, l: m_len, d: m_data};
            n_chk++;
            if (q.size() == 0) begin
              n_fail++;
              $display("FAIL mac_beat unexpected: got %h, required none",
                       act);
            end else begin
              e = q.pop_front();
              if (act.v !== e.v || act.c !== e.c ||
                  (e.v && (act.s !== e.s || act.t !== e.t ||
                           act.l !== e.l || act.d !== e.d))) begin
                n_fail++;
                $display("FAIL mac_beat: got %h, required %h", act, e);
              end
            end
          end
        end
      end

      begin : stimulus
        repeat (2) @(negedge clk);
        chk("rst valid", m_valid, 0);
        chk("rst cancel", m_cancel, 0);
        chk("rst err", m_err, 0);
        chk("rst ready", m_ready, 0);
        chk("rst gb ready", gb_ready, 0);
        reset = 1'b0;

        // gearbox pattern and a beat driven into a stall slot
        for (int n = 1; n <= 12; n++) begin
          @(negedge clk);
          chk($sformatf("gb ready c%0d", n), gb_ready,
              32'((n % 4) != 3));
          if (n == 2) chk("gb err pre", gb_err, 0);
          if (n == 3) begin g_idle = 1'b0; g_start = 1'b1; end
          if (n == 4) begin
            chk("gb err stall", gb_err, 1);
            chk("gb valid stall", gb_valid, 0);
            g_idle = 1'b1; g_start = 1'b0;
          end
        end
        chk("gb valid end", gb_valid, 0);

        // basic frame, term len 5, one pad beat
        issue(16'hA1B2, 1'b1, 1'b0, 4'd0, 1'b0);
        exp_beat(16'hA1B2, 1'b1, 1'b0, 2'd2);
        data_beats(16'h1110, 3);
        issue(16'h4444, 1'b0, 1'b1, 4'd5, 1'b0);
        exp_beat(16'h4444, 1'b0, 1'b0, 2'd2);
        issue(16'h5555, 1'b0, 1'b0, 4'd0, 1'b0);
        exp_beat(16'h5555, 1'b0, 1'b0, 2'd2);
        issue(16'h6666, 1'b0, 1'b0, 4'd0, 1'b0);
        exp_beat(16'h6666, 1'b0, 1'b1, 2'd1);
        pad_beats(1);
        idle_cyc(2);
        chk("err frame1", m_err, 0);

        // term len 0, three pads, then straight into a start
        issue(16'h0102, 1'b1, 1'b0, 4'd0, 1'b0);
        exp_beat(16'h0102, 1'b1, 1'b0, 2'd2);
        data_beats(16'h2220, 3);
        issue(16'h0A0B, 1'b0, 1'b1, 4'd0, 1'b0);
        exp_beat(16'h0A0B, 1'b0, 1'b1, 2'd0);
        pad_beats(3);
        // full-block term (len 8): no pad beats at all
        issue(16'h0C0D, 1'b1, 1'b0, 4'd0, 1'b0);
        exp_beat(16'h0C0D, 1'b1, 1'b0, 2'd2);
        data_beats(16'h3330, 3);
        issue(16'h7770, 1'b0, 1'b1, 4'd8, 1'b0);
        exp_beat(16'h7770, 1'b0, 1'b0, 2'd2);
        data_beats(16'h7771, 2);
        issue(16'h7773, 1'b0, 1'b0, 4'd0, 1'b0);
        exp_beat(16'h7773, 1'b0, 1'b1, 2'd2);
        issue(16'h0E0F, 1'b1, 1'b0, 4'd0, 1'b0);
        exp_beat(16'h0E0F, 1'b1, 1'b0, 2'd2);
        idle_cyc(1);
        chk("err len0/len8", m_err, 0);
        data_beats(16'h8880, 3);
        issue(16'h8883, 1'b0, 1'b1, 4'd2, 1'b0);
        exp_beat(16'h8883, 1'b0, 1'b1, 2'd2);
        pad_beats(3);
        idle_cyc(2);

        // cancel on the second data beat
        issue(16'h1234, 1'b1, 1'b0, 4'd0, 1'b0);
        exp_beat(16'h1234, 1'b1, 1'b0, 2'd2);
        data_beats(16'h4440, 1);
        issue(16'h4441, 1'b0, 1'b0, 4'd0, 1'b1);
        exp_cancel();
        pad_beats(2);
        issue(16'hBAD0, 1'b1, 1'b0, 4'd0, 1'b0);
        idle_cyc(1);
        issue(16'h5678, 1'b1, 1'b0, 4'd0, 1'b0);
        exp_beat(16'h5678, 1'b1, 1'b0, 2'd2);
        data_beats(16'h5550, 3);
        issue(16'h5553, 1'b0, 1'b1, 4'd3, 1'b0);
        exp_beat(16'h5553, 1'b0, 1'b0, 2'd2);
        issue(16'h5554, 1'b0, 1'b0, 4'd0, 1'b0);
        exp_beat(16'h5554, 1'b0, 1'b1, 2'd1);
        pad_beats(2);
        idle_cyc(1);
        chk("err cancel", m_err, 0);

        // cancel together with term, then with start
        issue(16'h6000, 1'b1, 1'b0, 4'd0, 1'b0);
        exp_beat(16'h6000, 1'b1, 1'b0, 2'd2);
        data_beats(16'h6010, 3);
        issue(16'h6020, 1'b0, 1'b1, 4'd4, 1'b1);
        exp_cancel();
        idle_cyc(2);
        issue(16'h6100, 1'b1, 1'b0, 4'd0, 1'b0);
        exp_beat(16'h6100, 1'b1, 1'b0, 2'd2);
        data_beats(16'h6110, 1);
        issue(16'h6120, 1'b1, 1'b0, 4'd0, 1'b1);
        exp_cancel();
        idle_cyc(2);
        chk("err cancel+x", m_err, 0);

        // start while in DATA
        issue(16'h9999, 1'b1, 1'b0, 4'd0, 1'b0);
        exp_beat(16'h9999, 1'b1, 1'b0, 2'd2);
        data_beats(16'h9990, 1);
        issue(16'hBEEF, 1'b1, 1'b0, 4'd0, 1'b0);
        exp_restart(16'hBEEF);
        idle_cyc(1);
        chk("err restart", m_err, 1);
        data_beats(16'hB000, 3);
        issue(16'hB003, 1'b0, 1'b1, 4'd1, 1'b0);
        exp_beat(16'hB003, 1'b0, 1'b1, 2'd1);
        pad_beats(3);
        idle_cyc(2);
        chk("err sticky", m_err, 1);

        // async reset while in TERM
        issue(16'hC000, 1'b1, 1'b0, 4'd0, 1'b0);
        exp_beat(16'hC000, 1'b1, 1'b0, 2'd2);
        data_beats(16'hC010, 3);
        issue(16'hC020, 1'b0, 1'b1, 4'd8, 1'b0);
        exp_beat(16'hC020, 1'b0, 1'b0, 2'd2);
        idle_cyc(1);
        #2 reset = 1'b1;
        #1;
        chk("arst valid", m_valid, 0);
        chk("arst term", m_term, 0);
        chk("arst len", m_len, 0);
        chk("arst start", m_start, 0);
        chk("arst data", m_data, 0);
        chk("arst cancel", m_cancel, 0);
        chk("arst err", m_err, 0);
        chk("arst ready", m_ready, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        issue(16'hABCD, 1'b1, 1'b0, 4'd0, 1'b0);
        exp_beat(16'hABCD, 1'b1, 1'b0, 2'd2);
        data_beats(16'hD000, 3);
        issue(16'hD003, 1'b0, 1'b1, 4'd3, 1'b0);
        exp_beat(16'hD003, 1'b0, 1'b0, 2'd2);
        issue(16'hD004, 1'b0, 1'b0, 4'd0, 1'b0);
        exp_beat(16'hD004, 1'b0, 1'b1, 2'd1);
        pad_beats(2);
        idle_cyc(3);
        chk("err post rst", m_err, 0);
        chk("queue drained", q.size(), 0);
        done = 1'b1;
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
